// File: rtl/robertsons_mult_hs_if.sv
// Request/response bundle for robertsons_mult_hs.
//   master: the issuing datapath plus the result consumer (drives in_valid,
//           in_signed, q, m, out_ready).
//   slave : the multiplier (drives in_ready, out_valid, p, busy).
// Signals:
//   in_valid / in_ready   request handshake
//   in_signed             1 = both operands two's complement, 0 = unsigned
//   q / m                 multiplier / multiplicand, N bits each
//   out_valid / out_ready response handshake
//   p                     2N-bit product
//   busy                  multiplier is in CALC or DONE
interface robertsons_mult_hs_if #(
    parameter int unsigned N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [N-1:0]   q;
    logic [N-1:0]   m;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p;
    logic           busy;

    modport master (
        output in_valid,
        output in_signed,
        output q,
        output m,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  p,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_signed,
        input  q,
        input  m,
        input  out_ready,
        output in_ready,
        output out_valid,
        output p,
        output busy
    );
endinterface

// File: rtl/robertsons_mult_hs.sv
// Handshaked sequential multiplier using Robertson's algorithm.
// One multiply in flight; each transaction takes exactly N CALC cycles, then
// the product is held in DONE until the consumer accepts it.
// Ports:
//   clk   rising-edge clock
//   reset synchronous, active-high; overrides everything
//   bus   robertsons_mult_hs_if slave modport (request, response, busy)
module robertsons_mult_hs #(
    parameter int unsigned N = 8
) (
    input logic                 clk,
    input logic                 reset,
    robertsons_mult_hs_if.slave bus
);
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        Idle,
        Calc,
        Done
    } state_e;

    state_e         state_q;
    logic [N:0]     a_q;       // accumulator, one guard bit for carry / sign
    logic [N-1:0]   qr_q;      // multiplier, shifted right as product LSBs fill in
    logic [N-1:0]   m_q;
    logic           sgn_q;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] p_q;
    logic           out_valid_q;

    logic [N:0]     m_ext;
    logic [N:0]     addend;
    logic [N:0]     sum;
    logic [N:0]     a_d;
    logic [N-1:0]   qr_d;
    logic           last;

    // One Robertson step. In signed mode the multiplier MSB carries weight
    // -2^(N-1), so the last step subtracts M instead of adding it.
    always_comb begin
        m_ext  = sgn_q ? {m_q[N-1], m_q} : {1'b0, m_q};
        addend = qr_q[0] ? m_ext : '0;
        last   = (cnt_q == CW'(N - 1));
        sum    = (sgn_q && last) ? (a_q - addend) : (a_q + addend);
        // Arithmetic shift in signed mode; logical keeps the unsigned carry.
        a_d    = {sgn_q & sum[N], sum[N:1]};
        qr_d   = {sum[0], qr_q[N-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= Idle;
            a_q         <= '0;
            qr_q        <= '0;
            m_q         <= '0;
            sgn_q       <= 1'b0;
            cnt_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                Idle: begin
                    // in_ready is simply Idle and not reset, which holds here.
                    if (bus.in_valid) begin
                        m_q     <= bus.m;
                        qr_q    <= bus.q;
                        sgn_q   <= bus.in_signed;
                        a_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= Calc;
                    end
                end
                Calc: begin
                    a_q   <= a_d;
                    qr_q  <= qr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        p_q         <= {a_d[N-1:0], qr_d};
                        out_valid_q <= 1'b1;
                        state_q     <= Done;
                    end
                end
                Done: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= Idle;
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == Idle) && !reset;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.busy      = (state_q != Idle);
endmodule

// File: tb/tb_robertsons_mult_hs.sv
// Self-checking bench for robertsons_mult_hs: directed N=8 cases (latency,
// corner products, backpressure, reset abort, back-to-back) and random
// sweeps on N=4 and N=16 instances. Expected products go into per-instance
// queues when a request is committed and are popped as results emerge.
module tb_robertsons_mult_hs;
    localparam int NREQ = 1000;
    localparam int TMO  = 40;

    localparam bit          CS [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [7:0]  CQ [8] = '{8'h80, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'hA5, 8'h7F};
    localparam logic [7:0]  CM [8] = '{8'h80, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h5A, 8'h00, 8'h80};
    localparam logic [15:0] CP [8] = '{16'h4000, 16'hFF80, 16'h0080, 16'hFE01,
                                       16'h0001, 16'h0000, 16'h0000, 16'hC080};

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    longint sb8[$];
    longint sb4[$];
    longint sb16[$];

    robertsons_mult_hs_if #(.N(8))  b8  ();
    robertsons_mult_hs_if #(.N(4))  b4  ();
    robertsons_mult_hs_if #(.N(16)) b16 ();

    robertsons_mult_hs #(.N(8))  u_dut8  (.clk(clk), .reset(reset), .bus(b8));
    robertsons_mult_hs #(.N(4))  u_dut4  (.clk(clk), .reset(reset), .bus(b4));
    robertsons_mult_hs #(.N(16)) u_dut16 (.clk(clk), .reset(reset), .bus(b16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint sx(input longint v, input int w, input bit s);
        if (s && v[w-1]) return v - (longint'(1) << w);
        return v;
    endfunction

    function automatic longint ref_prod(input bit s, input longint qv, input longint mv,
                                        input int w);
        longint r;
        r = sx(qv, w, s) * sx(mv, w, s);
        return r & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Issue one N=8 request, scramble the inputs after acceptance, wait for
    // the result and take it. Returns product, cycles after accept, timeout.
    task automatic txn8(input bit s, input logic [7:0] qv, input logic [7:0] mv,
                        output logic [15:0] pv, output int lat, output bit to);
        int k;
        to  = 1'b0;
        lat = 0;
        pv  = '0;
        @(negedge clk);
        b8.in_valid  = 1'b1;
        b8.in_signed = s;
        b8.q         = qv;
        b8.m         = mv;
        k = 0;
        while (!b8.in_ready && k < TMO) begin
            @(negedge clk);
            k++;
        end
        if (!b8.in_ready) begin
            b8.in_valid = 1'b0;
            to = 1'b1;
            return;
        end
        @(negedge clk);
        b8.in_valid  = 1'b0;
        b8.in_signed = ~s;
        b8.q         = 8'($urandom);
        b8.m         = 8'($urandom);
        while (!b8.out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        if (!b8.out_valid) begin
            to = 1'b1;
            return;
        end
        pv = b8.p;
        b8.out_ready = 1'b1;
        @(negedge clk);
        b8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b8.in_valid = 1'b1;
        b8.q = 8'h12;
        b8.m = 8'h34;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({b8.in_ready, b8.out_valid, b8.busy, b8.p} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_state8: got %h, want %h",
                     {b8.in_ready, b8.out_valid, b8.busy, b8.p}, 19'h0);
        end
        n_cmp++;
        if (b4.out_valid !== 1'b0 || b4.p !== 8'h0 || b16.out_valid !== 1'b0 ||
            b16.p !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state4_16: got v4=%b p4=%h v16=%b p16=%h, want all zero",
                     b4.out_valid, b4.p, b16.out_valid, b16.p);
        end
        b8.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (b8.in_ready !== 1'b1 || b8.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got in_ready=%b busy=%b, want in_ready=1 busy=0",
                     b8.in_ready, b8.busy);
        end
    endtask

    task automatic test_signed_basic();
        logic [15:0] pv;
        int lat;
        bit to;
        longint e;
        sb8.push_back(64'hFFF1);
        txn8(1'b1, 8'hFD, 8'h05, pv, lat, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL basic_timeout: got no handshake, want result within %0d cycles", TMO);
            void'(sb8.pop_front());
        end else begin
            e = sb8.pop_front();
            if (pv !== e[15:0]) begin
                n_bad++;
                $display("FAIL basic_product: got %h, want %h", pv, e[15:0]);
            end
            n_cmp++;
            if (lat != 8) begin
                n_bad++;
                $display("FAIL basic_latency: got %0d, want 8", lat);
            end
        end
    endtask

    task automatic test_corners();
        logic [15:0] pv;
        int lat;
        bit to;
        longint e;
        for (int i = 0; i < 8; i++) begin
            sb8.push_back(longint'(CP[i]));
            txn8(CS[i], CQ[i], CM[i], pv, lat, to);
            e = sb8.pop_front();
            n_cmp++;
            if (to || pv !== e[15:0] || lat != 8) begin
                n_bad++;
                $display("FAIL corner_%0d: got p=%h lat=%0d to=%b, want p=%h lat=8 to=0",
                         i, pv, lat, to, e[15:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        int lat;
        longint e;
        sb8.push_back(64'h0084);
        @(negedge clk);
        b8.in_valid  = 1'b1;
        b8.in_signed = 1'b0;
        b8.q         = 8'h0C;
        b8.m         = 8'h0B;
        n_cmp++;
        if (b8.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_idle_ready: got %b, want 1", b8.in_ready);
        end
        @(negedge clk);
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        e = sb8.pop_front();
        held = b8.p;
        n_cmp++;
        if (b8.out_valid !== 1'b1 || b8.p !== e[15:0]) begin
            n_bad++;
            $display("FAIL bp_first: got v=%b p=%h, want v=1 p=%h", b8.out_valid, b8.p, e[15:0]);
        end
        // Competing request while the result is stalled.
        b8.in_valid  = 1'b1;
        b8.in_signed = 1'b0;
        b8.q         = 8'h02;
        b8.m         = 8'h03;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (b8.out_valid !== 1'b1 || b8.in_ready !== 1'b0 || b8.p !== 16'h0084) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got v=%b rdy=%b p=%h, want v=1 rdy=0 p=0084",
                         i, b8.out_valid, b8.in_ready, b8.p);
            end
        end
        sb8.push_back(64'h0006);
        b8.out_ready = 1'b1;
        @(negedge clk);
        b8.out_ready = 1'b0;
        n_cmp++;
        if (b8.out_valid !== 1'b0 || b8.busy !== 1'b0 || b8.in_ready !== 1'b1 ||
            b8.p !== 16'h0084) begin
            n_bad++;
            $display("FAIL bp_release: got v=%b busy=%b rdy=%b p=%h, want v=0 busy=0 rdy=1 p=0084",
                     b8.out_valid, b8.busy, b8.in_ready, b8.p);
        end
        @(negedge clk);
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        e = sb8.pop_front();
        n_cmp++;
        if (b8.out_valid !== 1'b1 || b8.p !== e[15:0] || lat != 8) begin
            n_bad++;
            $display("FAIL bp_second: got v=%b p=%h lat=%0d, want v=1 p=%h lat=8",
                     b8.out_valid, b8.p, lat, e[15:0]);
        end
        b8.out_ready = 1'b1;
        @(negedge clk);
        b8.out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [15:0] pv;
        int lat;
        bit to;
        longint e;
        @(negedge clk);
        b8.in_valid  = 1'b1;
        b8.in_signed = 1'b0;
        b8.q         = 8'h07;
        b8.m         = 8'h09;
        @(negedge clk);
        b8.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (b8.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_ready_in_reset: got %b, want 0", b8.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (b8.out_valid !== 1'b0 || b8.p !== 16'h0 || b8.in_ready !== 1'b1 ||
            b8.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_state: got v=%b p=%h rdy=%b busy=%b, want v=0 p=0000 rdy=1 busy=0",
                     b8.out_valid, b8.p, b8.in_ready, b8.busy);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (b8.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_result: got %b, want 0", b8.out_valid);
        end
        sb8.push_back(64'h003F);
        txn8(1'b0, 8'h07, 8'h09, pv, lat, to);
        e = sb8.pop_front();
        n_cmp++;
        if (to || pv !== e[15:0] || lat != 8) begin
            n_bad++;
            $display("FAIL abort_retry: got p=%h lat=%0d to=%b, want p=%h lat=8 to=0",
                     pv, lat, to, e[15:0]);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        longint e;
        sb8.push_back(64'h0100);
        @(negedge clk);
        b8.in_valid  = 1'b1;
        b8.in_signed = 1'b0;
        b8.q         = 8'h10;
        b8.m         = 8'h10;
        b8.out_ready = 1'b1;
        @(negedge clk);
        // Second request held from here; it waits until Idle.
        sb8.push_back(64'hFF00);
        b8.in_signed = 1'b1;
        b8.q         = 8'hF0;
        b8.m         = 8'h10;
        lat = 0;
        while (!b8.out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        e = sb8.pop_front();
        n_cmp++;
        if (b8.out_valid !== 1'b1 || b8.p !== e[15:0]) begin
            n_bad++;
            $display("FAIL b2b_first: got v=%b p=%h, want v=1 p=%h", b8.out_valid, b8.p, e[15:0]);
        end
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (b8.busy) b8.in_valid = 1'b0;
        end while (!b8.out_valid && gap < TMO);
        b8.in_valid = 1'b0;
        e = sb8.pop_front();
        n_cmp++;
        if (b8.out_valid !== 1'b1 || b8.p !== e[15:0] || gap != 10) begin
            n_bad++;
            $display("FAIL b2b_second: got v=%b p=%h gap=%0d, want v=1 p=%h gap=10",
                     b8.out_valid, b8.p, gap, e[15:0]);
        end
        @(negedge clk);
        b8.out_ready = 1'b0;
    endtask

    task automatic test_random_n4();
        longint e;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit pend = 1'b0;
        while (got < NREQ && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                b4.in_valid = 1'b0;
                pend = 1'b0;
            end
            b4.out_ready = 1'($urandom_range(0, 2) != 0);
            if (b4.out_valid && b4.out_ready) begin
                n_cmp++;
                if (sb4.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand4_extra: got p=%h, want no result", b4.p);
                end else begin
                    e = sb4.pop_front();
                    if (b4.p !== e[7:0]) begin
                        n_bad++;
                        $display("FAIL rand4_product: got %h, want %h", b4.p, e[7:0]);
                    end
                end
                got++;
            end
            if (!b4.in_valid && sent < NREQ && $urandom_range(0, 3) != 0) begin
                b4.in_signed = 1'($urandom_range(0, 1));
                b4.q         = 4'($urandom);
                b4.m         = 4'($urandom);
                b4.in_valid  = 1'b1;
            end
            if (b4.in_valid && b4.in_ready) begin
                sb4.push_back(ref_prod(b4.in_signed, longint'(b4.q), longint'(b4.m), 4));
                sent++;
                pend = 1'b1;
            end
        end
        @(negedge clk);
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b0;
        n_cmp++;
        if (got != NREQ || sent != NREQ || sb4.size() != 0) begin
            n_bad++;
            $display("FAIL rand4_count: got sent=%0d got=%0d left=%0d, want %0d/%0d/0",
                     sent, got, sb4.size(), NREQ, NREQ);
        end
    endtask

    task automatic test_random_n16();
        longint e;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit pend = 1'b0;
        while (got < NREQ && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                b16.in_valid = 1'b0;
                pend = 1'b0;
            end
            b16.out_ready = 1'($urandom_range(0, 2) != 0);
            if (b16.out_valid && b16.out_ready) begin
                n_cmp++;
                if (sb16.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand16_extra: got p=%h, want no result", b16.p);
                end else begin
                    e = sb16.pop_front();
                    if (b16.p !== e[31:0]) begin
                        n_bad++;
                        $display("FAIL rand16_product: got %h, want %h", b16.p, e[31:0]);
                    end
                end
                got++;
            end
            if (!b16.in_valid && sent < NREQ && $urandom_range(0, 3) != 0) begin
                b16.in_signed = 1'($urandom_range(0, 1));
                b16.q         = 16'($urandom);
                b16.m         = 16'($urandom);
                b16.in_valid  = 1'b1;
            end
            if (b16.in_valid && b16.in_ready) begin
                sb16.push_back(ref_prod(b16.in_signed, longint'(b16.q), longint'(b16.m), 16));
                sent++;
                pend = 1'b1;
            end
        end
        @(negedge clk);
        b16.in_valid  = 1'b0;
        b16.out_ready = 1'b0;
        n_cmp++;
        if (got != NREQ || sent != NREQ || sb16.size() != 0) begin
            n_bad++;
            $display("FAIL rand16_count: got sent=%0d got=%0d left=%0d, want %0d/%0d/0",
                     sent, got, sb16.size(), NREQ, NREQ);
        end
    endtask

    initial begin
        reset = 1'b1;
        b8.in_valid   = 1'b0;
        b8.in_signed  = 1'b0;
        b8.q          = '0;
        b8.m          = '0;
        b8.out_ready  = 1'b0;
        b4.in_valid   = 1'b0;
        b4.in_signed  = 1'b0;
        b4.q          = '0;
        b4.m          = '0;
        b4.out_ready  = 1'b0;
        b16.in_valid  = 1'b0;
        b16.in_signed = 1'b0;
        b16.q         = '0;
        b16.m         = '0;
        b16.out_ready = 1'b0;

        test_reset();
        test_signed_basic();
        test_corners();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random_n4();
        test_random_n16();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
